fetch_stage: RTL

- Instruction fetch stage directly upstream of decode.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle to decode as F_inst/F_pc/F_valid.
- Handles decode/hazard stalls and branch/jump redirects, including discarding in-flight responses.

---
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding decode.
// Owns the fetch PC, issues word requests on a valid/ready channel, tracks the
// PC of every in-flight request in order, buffers returned words in a small
// FIFO and presents the head to decode as F_inst/F_pc/F_valid.
// Redirects flush the FIFO and mark all in-flight responses for discard.
// Optional build macro FETCH_PERF_EN adds the F_stall_cnt/F_drop_cnt counters.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            F_stall,
    input  logic            F_redirect,
    input  logic [XLEN-1:0] F_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] F_inst,
    output logic [XLEN-1:0] F_pc,
    output logic            F_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     F_stall_cnt,
    output logic [31:0]     F_drop_cnt
`endif
);

    // Pointer width for the FIFO and the in-flight PC queue; counters need one
    // extra bit so that the value BUF_DEPTH itself is representable.
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

    // Fetching is held off until the first clock edge after reset release.
    logic             started_q;

    logic [XLEN-1:0]  pc_q,      pc_d;
    logic [CNT_W-1:0] out_q,     out_d;
    logic [CNT_W-1:0] drop_q,    drop_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0] pq_wr_q,   pq_wr_d;
    logic [PTR_W-1:0] pq_rd_q,   pq_rd_d;

    // Instruction FIFO storage and the in-order queue of requested PCs.
    logic [XLEN-1:0]  inst_mem [BUF_DEPTH];
    logic [XLEN-1:0]  pc_mem   [BUF_DEPTH];
    logic [XLEN-1:0]  pcq_mem  [BUF_DEPTH];

    logic             pop;
    logic             rsp_fire;
    logic             rsp_drop;
    logic             push;
    logic             accept;
    logic [CNT_W:0]   slots_used;

    // Word alignment of redirect targets simply ignores the two low bits.
    logic [1:0]       unused_target_lsb;
    assign unused_target_lsb = F_target[1:0];

    // Handshakes, credit check and the decode-facing outputs.
    always_comb begin
        F_valid   = (cnt_q != '0);
        pop       = F_valid && !F_stall && !F_redirect;
        // A response with nothing outstanding (e.g. one issued before a reset)
        // is not ours and is ignored entirely.
        rsp_fire  = imem_rsp_valid && (out_q != '0);
        rsp_drop  = rsp_fire && (F_redirect || (drop_q != '0));
        push      = rsp_fire && !rsp_drop;
        // Slots in use: in-flight requests plus buffered words. A head pop in
        // this cycle frees its slot at the same edge at which a new request
        // could be accepted, and that request's data cannot arrive before the
        // following edge, so the popped slot is already free for it. This is
        // what sustains one instruction per cycle with a two-entry buffer.
        slots_used = {1'b0, out_q} + {1'b0, cnt_q} - {{CNT_W{1'b0}}, pop};
        imem_req_valid = started_q && !F_redirect && (slots_used < DEPTH_L);
        imem_addr = pc_q;
        accept    = imem_req_valid && imem_req_ready;
        F_inst    = F_valid ? inst_mem[rd_ptr_q] : '0;
        F_pc      = F_valid ? pc_mem[rd_ptr_q]   : '0;
    end

    // Next-state for PC, outstanding/drop counters and queue pointers.
    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + CNT_W'(accept) - CNT_W'(rsp_fire);
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pq_wr_d  = pq_wr_q + PTR_W'(accept);
        pq_rd_d  = pq_rd_q + PTR_W'(rsp_fire);

        if (F_redirect) begin
            // Everything still in flight belongs to the old path. No request
            // is accepted this cycle, so out_d equals the new drop count.
            pc_d     = {F_target[XLEN-1:2], 2'b00};
            drop_d   = out_q - CNT_W'(rsp_fire);
            cnt_d    = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (accept) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
            cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pq_wr_q   <= '0;
            pq_rd_q   <= '0;
        end else begin
            started_q <= 1'b1;
            pc_q      <= pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pq_wr_q   <= pq_wr_d;
            pq_rd_q   <= pq_rd_d;
        end
    end

    // Storage writes: record requested PCs, and pair accepted data with the
    // oldest in-flight PC. Pointers alone define validity, so no reset here.
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pq_wr_q] <= pc_q;
        end
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= pcq_mem[pq_rd_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] drop_cnt_q;

    // Performance counters: stalled-with-valid cycles and discarded responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (F_valid && F_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (rsp_drop) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign F_stall_cnt = stall_cnt_q;
    assign F_drop_cnt  = drop_cnt_q;
`endif

endmodule
